// File: rtl/i2c_frame_rx.sv
// I2C frame receiver: START/STOP detection, byte assembly, ACK capture and bus tracking.
// Optional SCL-stuck timeout is compiled in with `define I2C_FRAME_RX_TIMEOUT_EN.
module i2c_frame_rx #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       scl_in,
  input  logic       past_sda_in,
  input  logic       past_scl_in,
  output logic       start_det,
  output logic       stop_det,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       is_addr,
  output logic       ack_out,
  output logic       ack_valid,
  output logic       bus_busy,
  output logic       frame_err,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       addr_pend_q, addr_pend_d;
  logic       is_addr_q, is_addr_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       byte_valid_q, byte_valid_d;
  logic       ack_valid_q, ack_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       to_fire;

  logic start_c, stop_c, rise_c;
  assign start_c = past_scl_in & scl_in & past_sda_in & ~sda_in;
  assign stop_c  = past_scl_in & scl_in & ~past_sda_in & sda_in;
  assign rise_c  = ~past_scl_in & scl_in;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    addr_pend_d  = addr_pend_q;
    is_addr_d    = is_addr_q;
    ack_d        = ack_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    byte_valid_d = 1'b0;
    ack_valid_d  = 1'b0;
    frame_err_d  = 1'b0;

    if (start_c) begin
      state_d     = S_DATA;
      cnt_d       = 4'd0;
      addr_pend_d = 1'b1;
      start_d     = 1'b1;
      busy_d      = 1'b1;
    end else if (stop_c) begin
      // A STOP mid-byte or before the ACK bit leaves a truncated frame.
      frame_err_d = ((state_q == S_DATA) && (cnt_q != 4'd0)) || (state_q == S_ACK);
      state_d     = S_IDLE;
      stop_d      = 1'b1;
      busy_d      = 1'b0;
    end else if (to_fire) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (rise_c) begin
      case (state_q)
        S_DATA: begin
          shift_d = {shift_q[6:0], sda_in};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            byte_d       = {shift_q[6:0], sda_in};
            byte_valid_d = 1'b1;
            is_addr_d    = addr_pend_q;
            state_d      = S_ACK;
          end
        end
        S_ACK: begin
          ack_d       = ~sda_in;
          ack_valid_d = 1'b1;
          addr_pend_d = 1'b0;
          cnt_d       = 4'd0;
          state_d     = S_DATA;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      shift_q      <= 8'h00;
      byte_q       <= 8'h00;
      addr_pend_q  <= 1'b0;
      is_addr_q    <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      ack_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      addr_pend_q  <= addr_pend_d;
      is_addr_q    <= is_addr_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      byte_valid_q <= byte_valid_d;
      ack_valid_q  <= ack_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef I2C_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q;

  // Counts busy cycles with a frozen SCL; any edge or bus condition restarts it.
  always_comb begin
    to_cnt_d = '0;
    to_fire  = 1'b0;
    if (busy_q && (scl_in == past_scl_in) && !start_c && !stop_c) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) to_fire = 1'b1;
      else                                     to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= to_fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  assign start_det  = start_q;
  assign stop_det   = stop_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign is_addr    = is_addr_q;
  assign ack_out    = ack_q;
  assign ack_valid  = ack_valid_q;
  assign bus_busy   = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/i2c_frame_rx.md
I2C_FRAME_RX -- requirements
Module: i2c_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: clk cycles of unchanged SCL level while the bus is busy before a timeout is declared.
REQ-002 SHALL have ports clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have ports rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have sda_in, input, 1: synchronized SDA from i2c_sync sda_out.
REQ-005 SHALL have scl_in, input, 1: synchronized SCL from i2c_sync scl_out.
REQ-006 SHALL have past_sda_in, input, 1: previous-cycle SDA from i2c_sync past_sda_out.
REQ-007 SHALL have past_scl_in, input, 1: previous-cycle SCL from i2c_sync past_scl_out.
REQ-008 SHALL have start_det, output, 1: one-cycle pulse on START or repeated START.
REQ-009 SHALL have stop_det, output, 1: one-cycle pulse on STOP.
REQ-010 SHALL have byte_out, output, 8: last received byte, MSB first on the wire.
REQ-011 SHALL have byte_valid, output, 1: one-cycle pulse when byte_out updates.
REQ-012 SHALL have is_addr, output, 1: byte_out is the first byte after a START; held with byte_out.
REQ-013 SHALL have ack_out and ack_valid, outputs, 1 each: ack_out=1 means ACK (SDA low on 9th bit); ack_valid pulses one cycle.
REQ-014 SHALL have bus_busy, frame_err and timeout, outputs, 1 each: bus busy level, truncated-byte pulse, and SCL-stuck pulse.

Function
REQ-015 SHALL detect conditions from the input pairs only: START = past_scl_in&scl_in&past_sda_in&~sda_in; STOP = past_scl_in&scl_in&~past_sda_in&sda_in; SCL rise = ~past_scl_in&scl_in.
REQ-016 SHALL register all outputs; each pulse appears exactly one clk after the qualifying input combination.
REQ-017 SHALL implement states IDLE, DATA and ACK; after reset the state is IDLE.
REQ-018 SHALL, on START in any state: enter DATA, clear the bit counter to 0, set the address-pending flag, pulse start_det and set bus_busy.
REQ-019 SHALL, in DATA on SCL rise, shift sda_in into an 8-bit shift register MSB first and increment a 4-bit counter.
REQ-020 SHALL, when the 8th bit is shifted: load byte_out, pulse byte_valid, drive is_addr from the address-pending flag and enter ACK.
REQ-021 SHALL, in ACK on SCL rise: set ack_out=~sda_in, pulse ack_valid, clear the address-pending flag, clear the counter and return to DATA.
REQ-022 SHALL, on STOP in any state: enter IDLE, pulse stop_det and clear bus_busy.
REQ-023 SHALL also pulse frame_err on that STOP if the state is DATA with counter 1..7, or the state is ACK.
REQ-024 SHALL ignore SCL rises and STOP-free SDA changes in IDLE; STOP while already in IDLE still pulses stop_det.
REQ-025 SHALL treat START and SCL rise as mutually exclusive (both need past_scl_in differently); no priority logic beyond START/STOP over data sampling.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: state IDLE, counter 0, shift register 0x00, byte_out 0x00, all pulses 0, is_addr 0, ack_out 0, bus_busy 0, timeout counter 0.
REQ-027 SHALL, on reset mid-byte, discard the partial byte without a frame_err pulse.

Configuration
REQ-028 SHALL, with macro I2C_FRAME_RX_TIMEOUT_EN defined, count clks while bus_busy=1 and scl_in==past_scl_in; any SCL change or START/STOP clears the count.
REQ-029 SHALL, when that count reaches TIMEOUT_CYCLES, pulse timeout, enter IDLE, clear bus_busy and clear the count; no stop_det is generated.
REQ-030 SHALL, without I2C_FRAME_RX_TIMEOUT_EN, omit the counter and tie timeout to 0; the port remains present.

Verification
REQ-031 SHALL cover: START, byte 0xA4, ACK (SDA=0), STOP -> start_det, byte_valid with byte_out=0xA4 and is_addr=1, ack_valid with ack_out=1, stop_det, bus_busy 1 then 0.
REQ-032 SHALL cover: START, 0x50+ACK, 0x3C+NACK, STOP -> second byte_valid with byte_out=0x3C and is_addr=0, ack_out=0.
REQ-033 SHALL cover: START, 0x50+ACK, repeated START, 0x51 -> second start_det and byte_out=0x51 with is_addr=1.
REQ-034 SHALL cover: START, 5 bits, STOP -> frame_err pulse coincident with stop_det, no byte_valid, state IDLE.
REQ-035 SHALL cover: with I2C_FRAME_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, START then SCL held low 16 clks -> timeout pulse, bus_busy=0; without the macro, timeout stays 0.
REQ-036 SHALL cover: rst_n asserted after 3 bits -> all outputs at reset values immediately, no frame_err; the next START/byte is received correctly.
